// File: rtl/core_mem_arbiter_if.sv
// Handshake and shared-bus signals between the fetch unit, the memory stage,
// the arbiter and the single-ported memory. The master modport is the
// arbiter's view: it drives the memory command and the requester acks.
interface core_mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_flush;
  logic        i_ack;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        owner;

  modport master (
    input  i_req, i_addr, i_flush,
    output i_ack, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_ack, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output owner
  );

  modport slave (
    output i_req, i_addr, i_flush,
    input  i_ack, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_ack, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  owner
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and memory-stage data share
// one bus with a single outstanding transaction. Data normally wins, but a
// streak counter lets a waiting fetch through after STARVE_MAX data grants.
// A fetch redirect (i_flush) marks an in-flight fetch as dropped so its
// response is swallowed while the bus transaction still completes cleanly.
module core_mem_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  core_mem_arbiter_if.master        bus_io
);

  localparam int StreakW = $clog2(STARVE_MAX + 2);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                memReq_q, memReq_d;
  logic                memWe_q, memWe_d;
  logic [31:0]         memAddr_q, memAddr_d;
  logic [31:0]         memWdata_q, memWdata_d;
  logic [3:0]          memBe_q, memBe_d;
  logic                owner_q, owner_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic                drop_q, drop_d;

  logic                iEligible;
  logic                anyRequest;
  logic                grantData;

  assign iEligible  = bus_io.i_req & ~bus_io.i_flush;
  assign anyRequest = iEligible | bus_io.d_req;
  assign grantData  = bus_io.d_req & ~(iEligible & (streak_q == StreakMax));

  // State and command registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      memBe_q    <= '0;
      owner_q    <= 1'b0;
      streak_q   <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      memBe_q    <= memBe_d;
      owner_q    <= owner_d;
      streak_q   <= streak_d;
      drop_q     <= drop_d;
    end
  end

  // Next-state: pick a winner in IDLE, hold the command until granted,
  // then wait for the single response while tracking fetch redirects.
  always_comb begin
    state_d    = state_q;
    memReq_d   = memReq_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    memBe_d    = memBe_q;
    owner_d    = owner_q;
    streak_d   = streak_q;
    drop_d     = drop_q;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (anyRequest) begin
          state_d  = REQ;
          memReq_d = 1'b1;
          owner_d  = grantData;
          if (grantData) begin
            memWe_d    = bus_io.d_we;
            memAddr_d  = bus_io.d_addr;
            memWdata_d = bus_io.d_wdata;
            memBe_d    = bus_io.d_be;
            if (!iEligible) begin
              streak_d = '0;
            end else if (streak_q != StreakMax) begin
              streak_d = streak_q + StreakW'(1);
            end
          end else begin
            memWe_d    = 1'b0;
            memAddr_d  = bus_io.i_addr;
            memWdata_d = '0;
            memBe_d    = 4'hF;
            streak_d   = '0;
          end
        end
      end
      REQ: begin
        if (bus_io.i_flush && !owner_q) begin
          drop_d = 1'b1;
        end
        if (bus_io.mem_gnt) begin
          state_d  = WAIT;
          memReq_d = 1'b0;
        end
      end
      WAIT: begin
        if (bus_io.i_flush && !owner_q) begin
          drop_d = 1'b1;
        end
        if (bus_io.mem_rvalid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        memReq_d = 1'b0;
        drop_d   = 1'b0;
      end
    endcase
  end

  // Outputs: registered command, passthrough read data, and same-cycle acks
  // on the response; a dropped or concurrently flushed fetch gets no ack.
  always_comb begin
    bus_io.mem_req   = memReq_q;
    bus_io.mem_we    = memWe_q;
    bus_io.mem_addr  = memAddr_q;
    bus_io.mem_wdata = memWdata_q;
    bus_io.mem_be    = memBe_q;
    bus_io.owner     = owner_q;
    bus_io.i_rdata   = bus_io.mem_rdata;
    bus_io.d_rdata   = bus_io.mem_rdata;
    bus_io.i_ack     = 1'b0;
    bus_io.d_ack     = 1'b0;
    if (state_q == WAIT && bus_io.mem_rvalid) begin
      if (owner_q) begin
        bus_io.d_ack = 1'b1;
      end else begin
        bus_io.i_ack = ~drop_q & ~bus_io.i_flush;
      end
    end
  end

endmodule
